scene_compositor: RTL and testbench

//  Per-pixel colour source for the LCD timing driver: takes the driver's one-pixel-ahead

---
 rtl/scene_compositor_pkg.sv | 28 ++
 rtl/scene_compositor_pipe_hit.sv | 15 +
 rtl/scene_compositor.sv | 114 +++++++++++
 tb/tb_scene_compositor.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/scene_compositor_pkg.sv
// scene_compositor_pkg: display geometry, object sizes, colours and FSM states shared by the compositor
//   Contents: coordinate width CW and object-bound width BW, display and object dimensions,
//   scene colours, state_t, and in_span() for half-open range tests without wrap-around.
package scene_compositor_pkg;
  localparam int CW = 12;
  localparam int BW = 13;
  localparam int H_DISP = 1024;
  localparam int V_DISP = 768;
  localparam int NUM_PIPES = 3;
  localparam logic [CW-1:0] BIRD_X = 12'd200;
  localparam logic [CW-1:0] BIRD_W = 12'd34;
  localparam logic [CW-1:0] BIRD_H = 12'd24;
  localparam logic [CW-1:0] PIPE_W = 12'd52;
  localparam logic [CW-1:0] GAP_H = 12'd160;
  localparam logic [CW-1:0] GROUND_Y = 12'd700;
  localparam logic [CW-1:0] X_LAST = CW'(H_DISP - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(V_DISP - 1);
  localparam logic [CW-1:0] BIRD_Y_RST = CW'(V_DISP / 2);
  localparam logic [23:0] C_SKY = 24'h70C5CE;
  localparam logic [23:0] C_GND = 24'hDED895;
  localparam logic [23:0] C_PIPE = 24'h5EE270;
  localparam logic [23:0] C_BIRD = 24'hF8E038;
  typedef enum logic [1:0] {WAIT_VS, DRAW, REPORT} state_t;
  // Upper bound is formed in BW bits so objects near 4095 clip instead of wrapping to 0.
  function automatic logic in_span(input logic [CW-1:0] v, input logic [CW-1:0] lo, input logic [CW-1:0] len);
    return (v >= lo) && ({1'b0, v} < ({1'b0, lo} + {1'b0, len}));
  endfunction
endpackage

// File: rtl/scene_compositor_pipe_hit.sv
// scene_compositor_pipe_hit: combinational test of one pixel against one pipe pair
//   Ports: x, y (pixel), pipe_x (left column), gap_y (gap top line), en (pipe drawn),
//   hit (pixel lies on the pipe body, outside its gap).
module scene_compositor_pipe_hit
  import scene_compositor_pkg::*;
(
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic [CW-1:0] pipe_x,
  input  logic [CW-1:0] gap_y,
  input  logic          en,
  output logic          hit
);
  assign hit = en && in_span(x, pipe_x, PIPE_W) && !in_span(y, gap_y, GAP_H);
endmodule

// File: rtl/scene_compositor.sv
// scene_compositor: per-pixel scene colour with frame-synchronous object buffering and collision report
//   Inputs:  clk, rst_n (async active-low), lcd_vs (active-low vsync), pix_valid, lcd_xpos, lcd_ypos,
//            obj_update (capture pulse), bird_y, pipe_x/pipe_gap_y (12 bits per pipe), pipe_en.
//   Outputs: lcd_data (colour of previous cycle's request), frame_done, hit, hit_valid.
module scene_compositor
  import scene_compositor_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    lcd_vs,
  input  logic                    pix_valid,
  input  logic [CW-1:0]           lcd_xpos,
  input  logic [CW-1:0]           lcd_ypos,
  input  logic                    obj_update,
  input  logic [CW-1:0]           bird_y,
  input  logic [CW*NUM_PIPES-1:0] pipe_x,
  input  logic [CW*NUM_PIPES-1:0] pipe_gap_y,
  input  logic [NUM_PIPES-1:0]    pipe_en,
  output logic [23:0]             lcd_data,
  output logic                    frame_done,
  output logic                    hit,
  output logic                    hit_valid
);
  state_t state, state_next;
  logic vs_q, vs_fall, dirty, hit_acc;
  logic [CW-1:0] pend_bird, act_bird;
  logic [CW*NUM_PIPES-1:0] pend_px, act_px, pend_gy, act_gy;
  logic [NUM_PIPES-1:0] pend_en, act_en, pipe_hits;
  logic bird, gnd, pipe_any, cur_hit, last;
  logic [23:0] colour;
  // vs_fall is itself a flop so it lands one cycle after lcd_vs is first seen low.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vs_q <= 1'b1;
      vs_fall <= 1'b0;
    end else begin
      vs_q <= lcd_vs;
      vs_fall <= vs_q & ~lcd_vs;
    end
  // An update coinciding with vs_fall stays pending; the frame starting now uses the older set.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend_bird <= BIRD_Y_RST;
      act_bird <= BIRD_Y_RST;
      pend_px <= '0;
      act_px <= '0;
      pend_gy <= '0;
      act_gy <= '0;
      pend_en <= '0;
      act_en <= '0;
      dirty <= 1'b0;
    end else begin
      if (obj_update) begin
        pend_bird <= bird_y;
        pend_px <= pipe_x;
        pend_gy <= pipe_gap_y;
        pend_en <= pipe_en;
      end
      if (vs_fall && dirty) begin
        act_bird <= pend_bird;
        act_px <= pend_px;
        act_gy <= pend_gy;
        act_en <= pend_en;
      end
      dirty <= obj_update | (dirty & ~vs_fall);
    end
  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
    scene_compositor_pipe_hit u_pipe_hit (
      .x(lcd_xpos),
      .y(lcd_ypos),
      .pipe_x(act_px[CW*i +: CW]),
      .gap_y(act_gy[CW*i +: CW]),
      .en(act_en[i]),
      .hit(pipe_hits[i])
    );
  end
  always_comb begin
    pipe_any = |pipe_hits;
    bird = in_span(lcd_xpos, BIRD_X, BIRD_W) && in_span(lcd_ypos, act_bird, BIRD_H);
    gnd = lcd_ypos >= GROUND_Y;
    colour = bird ? C_BIRD : pipe_any ? C_PIPE : gnd ? C_GND : C_SKY;
    cur_hit = pix_valid && bird && (pipe_any || gnd);
    last = pix_valid && lcd_xpos == X_LAST && lcd_ypos == Y_LAST;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lcd_data <= '0;
    else lcd_data <= pix_valid ? colour : 24'h0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= WAIT_VS;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      WAIT_VS: state_next = vs_fall ? DRAW : WAIT_VS;
      DRAW:    state_next = (!vs_fall && last) ? REPORT : DRAW;
      default: state_next = WAIT_VS;
    endcase
  end
  always_comb begin
    frame_done = state == REPORT;
    hit_valid = state == REPORT;
  end
  // hit is loaded on the last pixel so it is already valid while hit_valid is high.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hit_acc <= 1'b0;
      hit <= 1'b0;
    end else begin
      if (state == DRAW && vs_fall) hit_acc <= 1'b0;
      else if (state == DRAW && cur_hit) hit_acc <= 1'b1;
      else if (state == REPORT) hit_acc <= 1'b0;
      if (state == DRAW && !vs_fall && last) hit <= hit_acc | cur_hit;
    end
endmodule

// File: tb/tb_scene_compositor.sv
// tb_scene_compositor: directed checks of colour lookup, object buffering and frame collision reports
module tb_scene_compositor;
  localparam logic [23:0] SKY = 24'h70C5CE;
  localparam logic [23:0] GND = 24'hDED895;
  localparam logic [23:0] PIPE = 24'h5EE270;
  localparam logic [23:0] BIRD = 24'hF8E038;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lcd_vs = 1'b1;
  logic pix_valid = 1'b0;
  logic [11:0] lcd_xpos = '0, lcd_ypos = '0;
  logic obj_update = 1'b0;
  logic [11:0] bird_y = '0;
  logic [35:0] pipe_x = '0, pipe_gap_y = '0;
  logic [2:0] pipe_en = '0;
  logic [23:0] lcd_data;
  logic frame_done, hit, hit_valid;
  int n_vec = 0, n_err = 0, hv_cnt = 0, hv_snap;
  scene_compositor dut (
    .clk(clk), .rst_n(rst_n), .lcd_vs(lcd_vs), .pix_valid(pix_valid),
    .lcd_xpos(lcd_xpos), .lcd_ypos(lcd_ypos), .obj_update(obj_update),
    .bird_y(bird_y), .pipe_x(pipe_x), .pipe_gap_y(pipe_gap_y), .pipe_en(pipe_en),
    .lcd_data(lcd_data), .frame_done(frame_done), .hit(hit), .hit_valid(hit_valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (hit_valid) hv_cnt++;
  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic req(input string tag, input logic [11:0] x, input logic [11:0] y, input logic [23:0] exp);
    @(negedge clk);
    pix_valid = 1'b1;
    lcd_xpos = x;
    lcd_ypos = y;
    @(negedge clk);
    pix_valid = 1'b0;
    chk(tag, lcd_data, exp);
  endtask
  task automatic upd(input logic [11:0] by, input logic [2:0] en);
    @(negedge clk);
    bird_y = by;
    pipe_en = en;
    obj_update = 1'b1;
    @(negedge clk);
    obj_update = 1'b0;
  endtask
  task automatic vsync(input bit u, input logic [11:0] by);
    @(negedge clk);
    lcd_vs = 1'b0;
    @(negedge clk);
    if (u) begin
      bird_y = by;
      obj_update = 1'b1;
    end
    @(negedge clk);
    obj_update = 1'b0;
    lcd_vs = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic end_frame(input string tag, input logic exp_hit);
    req({tag, "_last"}, 12'd1023, 12'd767, GND);
    chk({tag, "_hv"}, {23'b0, hit_valid}, 24'd1);
    chk({tag, "_fd"}, {23'b0, frame_done}, 24'd1);
    chk({tag, "_hit"}, {23'b0, hit}, {23'b0, exp_hit});
    @(negedge clk);
    chk({tag, "_hv_off"}, {23'b0, hit_valid}, 24'd0);
    chk({tag, "_hit_hold"}, {23'b0, hit}, {23'b0, exp_hit});
  endtask
  initial begin
    pipe_x = {12'd800, 12'd0, 12'd500};
    pipe_gap_y = {12'd100, 12'd0, 12'd300};
    repeat (3) @(negedge clk);
    chk("rst_data", lcd_data, 24'h0);
    chk("rst_hit", {23'b0, hit}, 24'd0);
    chk("rst_hv", {23'b0, hit_valid}, 24'd0);
    chk("rst_fd", {23'b0, frame_done}, 24'd0);
    rst_n = 1'b1;
    vsync(0, 12'd0);
    req("t1_bird", 12'd200, 12'd384, BIRD);
    req("t1_sky", 12'd0, 12'd0, SKY);
    req("t1_gnd", 12'd0, 12'd700, GND);
    req("t1_bird_edge", 12'd233, 12'd407, BIRD);
    req("t1_bird_out", 12'd234, 12'd384, SKY);
    end_frame("t1", 1'b0);
    upd(12'd384, 3'b101);
    vsync(0, 12'd0);
    @(negedge clk);
    pix_valid = 1'b1;
    lcd_xpos = 12'd500;
    lcd_ypos = 12'd299;
    #1 chk("t2_latency", lcd_data, 24'h0);
    @(negedge clk);
    pix_valid = 1'b0;
    chk("t2_pipe_top", lcd_data, PIPE);
    @(negedge clk);
    chk("t2_invalid", lcd_data, 24'h0);
    req("t2_gap", 12'd500, 12'd300, SKY);
    req("t2_gap_end", 12'd500, 12'd459, SKY);
    req("t2_pipe_bot", 12'd500, 12'd460, PIPE);
    req("t2_right_out", 12'd552, 12'd100, SKY);
    req("t2_right_in", 12'd551, 12'd100, PIPE);
    req("t2_pipe_over_gnd", 12'd500, 12'd720, PIPE);
    req("t2_pipe2", 12'd800, 12'd50, PIPE);
    req("t2_pipe2_gap", 12'd800, 12'd150, SKY);
    req("t2_pipe1_off", 12'd10, 12'd10, SKY);
    end_frame("t2", 1'b0);
    vsync(0, 12'd0);
    upd(12'd100, 3'b101);
    req("t3_old_bird", 12'd200, 12'd384, BIRD);
    req("t3_new_hidden", 12'd200, 12'd100, SKY);
    end_frame("t3", 1'b0);
    vsync(0, 12'd0);
    req("t3_new_bird", 12'd200, 12'd100, BIRD);
    req("t3_old_gone", 12'd200, 12'd384, SKY);
    end_frame("t3b", 1'b0);
    upd(12'd200, 3'b101);
    vsync(1, 12'd500);
    req("t4_old_pend", 12'd200, 12'd200, BIRD);
    req("t4_new_hidden", 12'd200, 12'd500, SKY);
    end_frame("t4", 1'b0);
    vsync(0, 12'd0);
    req("t4_new_bird", 12'd200, 12'd500, BIRD);
    req("t4_prev_gone", 12'd200, 12'd200, SKY);
    end_frame("t4b", 1'b0);
    upd(12'd680, 3'b000);
    vsync(0, 12'd0);
    hv_snap = hv_cnt;
    req("t5_bird_gnd", 12'd200, 12'd701, BIRD);
    req("t5_pipe_off", 12'd500, 12'd100, SKY);
    end_frame("t5", 1'b1);
    chk("t5_hv_once", 24'(hv_cnt - hv_snap), 24'd1);
    upd(12'd300, 3'b000);
    vsync(0, 12'd0);
    req("t5_bird_air", 12'd200, 12'd300, BIRD);
    end_frame("t5b", 1'b0);
    upd(12'd680, 3'b000);
    vsync(0, 12'd0);
    req("t6_bird_gnd", 12'd200, 12'd701, BIRD);
    hv_snap = hv_cnt;
    vsync(0, 12'd0);
    chk("t6_trunc_no_hv", 24'(hv_cnt - hv_snap), 24'd0);
    end_frame("t6_after_trunc", 1'b0);
    vsync(0, 12'd0);
    req("t6_bird_gnd2", 12'd200, 12'd701, BIRD);
    end_frame("t6_hit", 1'b1);
    vsync(0, 12'd0);
    req("t6_bird_gnd3", 12'd200, 12'd701, BIRD);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_data", lcd_data, 24'h0);
    chk("t6_rst_hit", {23'b0, hit}, 24'd0);
    chk("t6_rst_hv", {23'b0, hit_valid}, 24'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hv_snap = hv_cnt;
    req("t6_rst_bird", 12'd200, 12'd384, BIRD);
    req("t6_rst_last", 12'd1023, 12'd767, GND);
    chk("t6_rst_no_hv", {23'b0, hit_valid}, 24'd0);
    @(negedge clk);
    chk("t6_rst_no_report", 24'(hv_cnt - hv_snap), 24'd0);
    vsync(0, 12'd0);
    end_frame("t6_full", 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
